// File: rtl/id_issue_stage_pkg.sv
// Shared constants and bundle types for the decode/issue stage.
package id_issue_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CTRL_W   = 16;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Highest count a per-register in-flight counter can hold.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Instruction fields captured from fetch.
  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [ADDR_W-1:0] rd;
    logic              rd_we;
    logic [CTRL_W-1:0] ctrl;
  } fs_to_ds_t;

  // Resolved issue bundle handed to execute.
  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ADDR_W-1:0] rd;
    logic              rd_we;
    logic [CTRL_W-1:0] ctrl;
  } ds_to_es_t;

endpackage

// File: rtl/id_issue_stage_if.sv
// Fetch->decode and decode->execute handshake bundle. The master modport is
// the issue stage's view; the slave modport is the surrounding pipeline.
interface id_issue_stage_if;
  import id_issue_stage_pkg::*;

  logic              fs_to_ds_valid;
  logic              ds_allowin;
  logic [ADDR_W-1:0] fs_rs1;
  logic [ADDR_W-1:0] fs_rs2;
  logic              fs_use_rs1;
  logic              fs_use_rs2;
  logic [ADDR_W-1:0] fs_rd;
  logic              fs_rd_we;
  logic [CTRL_W-1:0] fs_ctrl;

  logic              ds_to_es_valid;
  logic              es_allowin;
  logic [DATA_W-1:0] es_src1;
  logic [DATA_W-1:0] es_src2;
  logic [ADDR_W-1:0] es_rd;
  logic              es_rd_we;
  logic [CTRL_W-1:0] es_ctrl;

  modport master (
    input  fs_to_ds_valid, fs_rs1, fs_rs2, fs_use_rs1, fs_use_rs2,
           fs_rd, fs_rd_we, fs_ctrl, es_allowin,
    output ds_allowin, ds_to_es_valid, es_src1, es_src2, es_rd,
           es_rd_we, es_ctrl
  );

  modport slave (
    output fs_to_ds_valid, fs_rs1, fs_rs2, fs_use_rs1, fs_use_rs2,
           fs_rd, fs_rd_we, fs_ctrl, es_allowin,
    input  ds_allowin, ds_to_es_valid, es_src1, es_src2, es_rd,
           es_rd_we, es_ctrl
  );

endinterface

// File: rtl/id_issue_stage_reg_scoreboard.sv
// Per-register pending-write counters: one increment (issue) and one
// decrement (writeback) per cycle, with three read-side lookups.
module reg_scoreboard
  import id_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_idx,
  input  logic              dec_en,
  input  logic [ADDR_W-1:0] dec_idx,
  input  logic [ADDR_W-1:0] rs1_idx,
  input  logic [ADDR_W-1:0] rs2_idx,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [CNT_W-1:0]  cnt_rs1,
  output logic [CNT_W-1:0]  cnt_rs2,
  output logic [CNT_W-1:0]  cnt_rd
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  // Saturating up/down step; inc and dec together cancel, and a decrement at
  // zero holds zero instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic dec);
    if (inc && !dec) return (cur == CNT_MAX) ? cur : cur + CNT_W'(1);
    if (dec && !inc) return (cur == '0) ? cur : cur - CNT_W'(1);
    return cur;
  endfunction

  // Next counter values; r0 is never tracked.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == 0) cnt_d[r] = '0;
      else cnt_d[r] = cnt_next(cnt_q[r], inc_en && (inc_idx == ADDR_W'(r)),
                               dec_en && (dec_idx == ADDR_W'(r)));
    end
  end

  // Counter array state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_rs1 = cnt_q[rs1_idx];
  assign cnt_rs2 = cnt_q[rs2_idx];
  assign cnt_rd  = cnt_q[rd_idx];

  // A writeback to a register with nothing in flight means the pipeline lost
  // track of an instruction.
  dec_underflow_a: assert property (@(posedge clk) disable iff (!resetn)
    !(dec_en && (dec_idx != '0) && (cnt_q[dec_idx] == '0)));

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: holds one instruction, reads the register file,
// resolves RAW hazards against the pending-write scoreboard with same-cycle
// writeback bypass, and issues to execute over a valid/allowin handshake.
module id_issue_stage
  import id_issue_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  id_issue_stage_if.master    ds_if,
  input  logic                flush,
  output logic [ADDR_W-1:0]   rf_raddr1,
  input  logic [DATA_W-1:0]   rf_rdata1,
  output logic [ADDR_W-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0]   rf_rdata2,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_waddr,
  input  logic [DATA_W-1:0]   wb_wdata
);

  logic      vld_p0_q, vld_p0_d;
  fs_to_ds_t ins_p0_q, ins_p0_d;
  fs_to_ds_t fs_ins;

  logic [CNT_W-1:0]  cnt_rs1, cnt_rs2, cnt_rd;
  logic [DATA_W:0]   res1, res2;
  logic              sat_stall, ready_go, es_valid, fire, load, rd_we_eff;
  ds_to_es_t         es_bus;

  // Operand for one source: bit DATA_W flags a RAW stall, the rest is data.
  // Only a single outstanding write that retires this very cycle can be
  // bypassed; deeper chains must wait for the older writes to drain.
  function automatic logic [DATA_W:0] resolve_src(
    input logic use_s, input logic [ADDR_W-1:0] rs, input logic [CNT_W-1:0] cnt,
    input logic [DATA_W-1:0] rf_data, input logic wb_hit,
    input logic [DATA_W-1:0] wb_data);
    if (!use_s || (rs == '0))          return '0;
    if (cnt == '0)                     return {1'b0, rf_data};
    if ((cnt == CNT_W'(1)) && wb_hit)  return {1'b0, wb_data};
    return {1'b1, {DATA_W{1'b0}}};
  endfunction

  assign fs_ins = '{rs1: ds_if.fs_rs1, rs2: ds_if.fs_rs2,
                    use_rs1: ds_if.fs_use_rs1, use_rs2: ds_if.fs_use_rs2,
                    rd: ds_if.fs_rd, rd_we: ds_if.fs_rd_we, ctrl: ds_if.fs_ctrl};

  assign rf_raddr1 = ins_p0_q.rs1;
  assign rf_raddr2 = ins_p0_q.rs2;

  assign res1 = resolve_src(ins_p0_q.use_rs1, ins_p0_q.rs1, cnt_rs1, rf_rdata1,
                            wb_we && (wb_waddr == ins_p0_q.rs1), wb_wdata);
  assign res2 = resolve_src(ins_p0_q.use_rs2, ins_p0_q.rs2, cnt_rs2, rf_rdata2,
                            wb_we && (wb_waddr == ins_p0_q.rs2), wb_wdata);

  assign rd_we_eff = ins_p0_q.rd_we && (ins_p0_q.rd != '0);
  assign sat_stall = rd_we_eff && (cnt_rd == CNT_MAX);
  assign ready_go  = !res1[DATA_W] && !res2[DATA_W] && !sat_stall;
  assign es_valid  = vld_p0_q && ready_go && !flush;
  assign fire      = es_valid && ds_if.es_allowin;

  assign ds_if.ds_allowin = !vld_p0_q || (ready_go && ds_if.es_allowin);
  assign load = ds_if.fs_to_ds_valid && ds_if.ds_allowin && !flush;

  assign es_bus = '{src1: res1[DATA_W-1:0], src2: res2[DATA_W-1:0],
                    rd: ins_p0_q.rd, rd_we: rd_we_eff, ctrl: ins_p0_q.ctrl};

  assign ds_if.ds_to_es_valid = es_valid;
  assign ds_if.es_src1        = es_bus.src1;
  assign ds_if.es_src2        = es_bus.src2;
  assign ds_if.es_rd          = es_bus.rd;
  assign ds_if.es_rd_we       = es_bus.rd_we;
  assign ds_if.es_ctrl        = es_bus.ctrl;

  reg_scoreboard u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .inc_en  (fire && rd_we_eff),
    .inc_idx (ins_p0_q.rd),
    .dec_en  (wb_we),
    .dec_idx (wb_waddr),
    .rs1_idx (ins_p0_q.rs1),
    .rs2_idx (ins_p0_q.rs2),
    .rd_idx  (ins_p0_q.rd),
    .cnt_rs1 (cnt_rs1),
    .cnt_rs2 (cnt_rs2),
    .cnt_rd  (cnt_rd)
  );

  // Stage occupancy: flush beats a simultaneous load, load beats issue.
  always_comb begin
    vld_p0_d = vld_p0_q;
    ins_p0_d = ins_p0_q;
    if (flush) begin
      vld_p0_d = 1'b0;
    end else if (load) begin
      vld_p0_d = 1'b1;
      ins_p0_d = fs_ins;
    end else if (fire) begin
      vld_p0_d = 1'b0;
    end
  end

  // ---- fetch -> decode stage boundary (p0) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0_q <= 1'b0;
      ins_p0_q <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      ins_p0_q <= ins_p0_d;
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: expected issues are queued when an
// instruction is offered and compared when execute accepts it.
module tb_id_issue_stage;
  import id_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  id_issue_stage_if bus();

  logic              flush, wb_we;
  logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, wb_waddr;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, wb_wdata;

  // Register file stand-in: register n reads as n*0x11.
  assign rf_rdata1 = DATA_W'(rf_raddr1) * 32'h11;
  assign rf_rdata2 = DATA_W'(rf_raddr2) * 32'h11;

  id_issue_stage dut (
    .clk       (clk),
    .resetn    (resetn),
    .ds_if     (bus),
    .flush     (flush),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata1 (rf_rdata1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata2 (rf_rdata2),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata)
  );

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] s1, input logic [31:0] s2,
                      input logic [4:0] rd, input logic we, input logic [15:0] ctrl);
    exp_t x;
    x.s1 = s1; x.s2 = s2; x.rd = rd; x.we = we; x.ctrl = ctrl;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present an instruction (call between posedge and negedge); returns just
  // after the edge that captured it, leaving fs_to_ds_valid asserted.
  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic [15:0] ctrl);
    int k;
    bus.fs_rs1 = rs1; bus.fs_rs2 = rs2; bus.fs_use_rs1 = u1; bus.fs_use_rs2 = u2;
    bus.fs_rd = rd; bus.fs_rd_we = we; bus.fs_ctrl = ctrl;
    bus.fs_to_ds_valid = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ds_allowin) break;
    end
    check("offer_accept", bus.ds_allowin, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.fs_to_ds_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  // Compare every accepted issue against the oldest expected entry.
  always @(negedge clk) begin
    if (resetn && bus.ds_to_es_valid && bus.es_allowin) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue_ctrl", bus.es_ctrl, 16'hxxxx);
      end else begin
        e = exp_q.pop_front();
        check("es_src1", bus.es_src1, e.s1);
        check("es_src2", bus.es_src2, e.s2);
        check("es_rd", bus.es_rd, e.rd);
        check("es_rd_we", bus.es_rd_we, e.we);
        check("es_ctrl", bus.es_ctrl, e.ctrl);
      end
    end
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    bus.fs_to_ds_valid = 1'b0; bus.fs_rs1 = '0; bus.fs_rs2 = '0;
    bus.fs_use_rs1 = 1'b0; bus.fs_use_rs2 = 1'b0; bus.fs_rd = '0;
    bus.fs_rd_we = 1'b0; bus.fs_ctrl = '0; bus.es_allowin = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_allowin", bus.ds_allowin, 1);
    check("rst_valid", bus.ds_to_es_valid, 0);
    check("rst_src1", bus.es_src1, 0);
    check("rst_src2", bus.es_src2, 0);
    check("rst_rd_we", bus.es_rd_we, 0);
    check("rst_ctrl", bus.es_ctrl, 0);
    check("rst_raddr1", rf_raddr1, 0);
    resetn = 1'b1;
    step();

    // Independent back-to-back stream
    for (int i = 1; i <= 3; i++) push(32'h11, 32'h22, 5'd3, 1'b1, 16'(16'h0100 + i));
    for (int i = 1; i <= 3; i++) offer(5'd1, 5'd2, 1, 1, 5'd3, 1, 16'(16'h0100 + i));
    idle();
    drain();
    check("cnt3_after_stream", dut.u_sb.cnt_q[3], 3);

    // Saturation stall on rd=3
    push(32'h11, 32'h22, 5'd3, 1'b1, 16'h0104);
    offer(5'd1, 5'd2, 1, 1, 5'd3, 1, 16'h0104);
    idle();
    @(negedge clk);
    check("sat_stall_valid", bus.ds_to_es_valid, 0);
    check("sat_stall_allowin", bus.ds_allowin, 0);
    step();
    wb(5'd3, 32'h33);
    drain();
    check("cnt3_after_sat", dut.u_sb.cnt_q[3], 3);
    wb(5'd3, 32'h33);
    wb(5'd3, 32'h33);
    check("cnt3_one", dut.u_sb.cnt_q[3], 1);

    // RAW on r3, bypass from the retiring writeback
    push(32'hDEADBEEF, 32'h22, 5'd6, 1'b1, 16'h0201);
    offer(5'd3, 5'd2, 1, 1, 5'd6, 1, 16'h0201);
    idle();
    @(negedge clk);
    check("raw_stall", bus.ds_to_es_valid, 0);
    step();
    wb(5'd3, 32'hDEADBEEF);
    check("raw_same_cycle_issue", exp_q.size(), 0);
    check("cnt3_zero", dut.u_sb.cnt_q[3], 0);
    check("cnt6_one", dut.u_sb.cnt_q[6], 1);

    // Two writes in flight to r7; first writeback must not unblock
    push(32'h0, 32'h0, 5'd7, 1'b1, 16'h0301);
    push(32'h0, 32'h0, 5'd7, 1'b1, 16'h0302);
    push(32'h0, 32'h00C0FFEE, 5'd0, 1'b0, 16'h0303);
    offer(5'd0, 5'd0, 0, 0, 5'd7, 1, 16'h0301);
    offer(5'd0, 5'd0, 0, 0, 5'd7, 1, 16'h0302);
    offer(5'd9, 5'd7, 0, 1, 5'd0, 1, 16'h0303);
    idle();
    @(negedge clk);
    check("r7_stall_cnt2", bus.ds_to_es_valid, 0);
    step();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h1111;
    @(negedge clk);
    check("r7_stall_first_wb", bus.ds_to_es_valid, 0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    check("cnt7_one", dut.u_sb.cnt_q[7], 1);
    wb(5'd7, 32'h00C0FFEE);
    check("r7_issue_second_wb", exp_q.size(), 0);
    check("cnt7_zero", dut.u_sb.cnt_q[7], 0);
    check("cnt0_zero", dut.u_sb.cnt_q[0], 0);

    // Issue and writeback of r4 in the same cycle
    push(32'h0, 32'h0, 5'd4, 1'b1, 16'h0401);
    offer(5'd0, 5'd0, 0, 0, 5'd4, 1, 16'h0401);
    idle();
    drain();
    check("cnt4_one", dut.u_sb.cnt_q[4], 1);
    push(32'h0, 32'h0, 5'd4, 1'b1, 16'h0402);
    offer(5'd0, 5'd0, 0, 0, 5'd4, 1, 16'h0402);
    idle();
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h4444;
    @(posedge clk); #1;
    wb_we = 1'b0;
    check("cnt4_inc_dec", dut.u_sb.cnt_q[4], 1);
    check("r4_issued", exp_q.size(), 0);
    wb(5'd4, 32'h4444);
    check("cnt4_zero", dut.u_sb.cnt_q[4], 0);

    // Flush a stalled instruction while fetch offers another
    offer(5'd6, 5'd0, 1, 0, 5'd8, 1, 16'h0501);
    idle();
    @(negedge clk);
    check("flush_pre_stall", bus.ds_to_es_valid, 0);
    step();
    flush = 1'b1;
    bus.fs_rs1 = 5'd0; bus.fs_use_rs1 = 1'b0; bus.fs_use_rs2 = 1'b0;
    bus.fs_rd = 5'd11; bus.fs_rd_we = 1'b1; bus.fs_ctrl = 16'h0502;
    bus.fs_to_ds_valid = 1'b1;
    @(negedge clk);
    check("flush_valid_low", bus.ds_to_es_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("flush_allowin", bus.ds_allowin, 1);
    check("flush_no_issue", bus.ds_to_es_valid, 0);
    check("flush_cnt6", dut.u_sb.cnt_q[6], 1);
    check("flush_cnt11", dut.u_sb.cnt_q[11], 0);
    step();
    wb(5'd6, 32'h6666);

    // Backpressure from execute
    bus.es_allowin = 1'b0;
    push(32'h11, 32'h22, 5'd9, 1'b1, 16'hBEEF);
    offer(5'd1, 5'd2, 1, 1, 5'd9, 1, 16'hBEEF);
    push(32'h22, 32'h11, 5'd10, 1'b1, 16'h1234);
    bus.fs_rs1 = 5'd2; bus.fs_rs2 = 5'd1; bus.fs_use_rs1 = 1'b1; bus.fs_use_rs2 = 1'b1;
    bus.fs_rd = 5'd10; bus.fs_rd_we = 1'b1; bus.fs_ctrl = 16'h1234;
    bus.fs_to_ds_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", bus.ds_to_es_valid, 1);
      check("bp_allowin", bus.ds_allowin, 0);
      check("bp_ctrl_held", bus.es_ctrl, 16'hBEEF);
      check("bp_rd_held", bus.es_rd, 9);
    end
    @(posedge clk); #1;
    bus.es_allowin = 1'b1;
    @(posedge clk); #1;
    idle();
    drain();
    check("cnt9_one", dut.u_sb.cnt_q[9], 1);
    check("cnt10_one", dut.u_sb.cnt_q[10], 1);

    // Asynchronous reset with a stalled instruction and cnt[5]=2
    push(32'h0, 32'h0, 5'd5, 1'b1, 16'h0601);
    push(32'h0, 32'h0, 5'd5, 1'b1, 16'h0602);
    offer(5'd0, 5'd0, 0, 0, 5'd5, 1, 16'h0601);
    offer(5'd0, 5'd0, 0, 0, 5'd5, 1, 16'h0602);
    offer(5'd5, 5'd0, 1, 0, 5'd12, 1, 16'h0603);
    idle();
    @(negedge clk);
    check("pre_reset_stall", bus.ds_to_es_valid, 0);
    check("pre_reset_cnt5", dut.u_sb.cnt_q[5], 2);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_allowin", bus.ds_allowin, 1);
    check("async_rst_valid", bus.ds_to_es_valid, 0);
    check("async_rst_cnt5", dut.u_sb.cnt_q[5], 0);
    check("async_rst_cnt9", dut.u_sb.cnt_q[9], 0);
    check("async_rst_rd", bus.es_rd, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
Decode/issue pipeline stage sitting directly upstream of the 32x32 register file and its consumer.
- Latches one decoded instruction from fetch and drives the register file read addresses.
- Tracks in-flight destination registers in a per-register pending-write scoreboard.
- Stalls on RAW hazards and bypasses same-cycle writeback data.
- Hands source operands to the execute stage with a valid/allowin handshake.

Parameters:
DATA_W, 32, operand/register width
ADDR_W, 5, register index width (2**ADDR_W registers; r0 hardwired zero)
CTRL_W, 16, opaque control payload width passed through to execute
CNT_W, 2, width of per-register in-flight counter (max 2**CNT_W-1 outstanding writes per reg)

Ports:
clk  in  1  clock; all state updates on posedge
resetn  in  1  asynchronous active-low reset
fs_to_ds_valid  in  1  fetch offers an instruction
ds_allowin  out  1  stage can accept this cycle
fs_rs1  in  ADDR_W  source 1 index
fs_rs2  in  ADDR_W  source 2 index
fs_use_rs1  in  1  instruction reads rs1
fs_use_rs2  in  1  instruction reads rs2
fs_rd  in  ADDR_W  destination index
fs_rd_we  in  1  instruction writes rd
fs_ctrl  in  CTRL_W  control payload
flush  in  1  kill the instruction held in this stage
rf_raddr1  out  ADDR_W  regfile read address 1 (= latched rs1)
rf_rdata1  in  DATA_W  regfile read data 1 (combinational)
rf_raddr2  out  ADDR_W  regfile read address 2
rf_rdata2  in  DATA_W  regfile read data 2
wb_we  in  1  writeback retiring a write this cycle (same signals drive regfile write port)
wb_waddr  in  ADDR_W  writeback destination
wb_wdata  in  DATA_W  writeback data
ds_to_es_valid  out  1  issue offered to execute
es_allowin  in  1  execute accepts
es_src1  out  DATA_W  resolved operand 1
es_src2  out  DATA_W  resolved operand 2
es_rd  out  ADDR_W  destination index
es_rd_we  out  1  destination write enable (0 when rd==0)
es_ctrl  out  CTRL_W  control payload

Behaviour:
- Reset (resetn low, async): ds_valid=0; all latched fields and all scoreboard counters cleared to 0. All outputs 0 except ds_allowin=1.
- Pipeline register:
  - Loads fs_* on posedge when fs_to_ds_valid && ds_allowin.
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go && !flush.
  - fire = ds_to_es_valid && es_allowin.
  - ds_valid: set by a load; cleared by fire with no load, or by flush.
- Flush: ds_valid <- 0 next edge. No scoreboard change. If fs_to_ds_valid is also asserted, flush wins and nothing is loaded. Already-issued instructions still write back normally.
- Scoreboard: cnt[r] per register, cnt[0] always 0.
  - inc[r] = fire && es_rd_we && es_rd==r
  - dec[r] = wb_we && wb_waddr==r && r!=0
  - Next cnt = cnt + inc - dec. Simultaneous inc and dec on the same r leaves cnt unchanged.
  - dec with cnt==0 is a protocol error: cnt holds 0; simulation assertion fires.
- Operand resolution for source s (only when use_s and rs!=0):
  - cnt==0: read regfile data.
  - cnt==1 and dec[rs] this cycle: bypass wb_wdata, not stalled.
  - Otherwise: RAW stall.
  - Unused source or rs==0: operand is 0 and never stalls.
- ds_ready_go = no RAW stall on either source AND (!rd_we || rd==0 || cnt[rd] < 2**CNT_W-1). The second term is a saturation stall.
- Latency: 0 cycles in-stage when hazard-free (issue on the cycle after capture); stall length equals wait for the producing writeback.
- es_rd_we forced 0 when rd==0 (r0 writes are not tracked).

Decomposition:
- Shared package (pipe_pkg): ADDR_W/DATA_W constants, NUM_REGS=2**ADDR_W, and the ds_to_es bundle typedef (src1, src2, rd, rd_we, ctrl).
- One natural sub-module: reg_scoreboard. It holds the counter array, takes inc/dec ports, and exposes per-index count lookups for rs1, rs2 and rd.

Test Plan:
- Reset mid-run, with a stalled instruction held and cnt[5]=2 → all cnt 0, ds_valid 0, ds_allowin 1 immediately (async).
- Independent stream (rs1=1, rs2=2, rd=3; es_allowin=1; rf_rdata1=0x11, rf_rdata2=0x22) → issues every cycle, es_src1=0x11, es_src2=0x22; cnt[3] increments per issue.
- RAW on r3 with cnt[3]=1, then wb_we=1/wb_waddr=3/wb_wdata=0xDEADBEEF → stalls until the wb cycle, then issues in that same cycle with es_src1=0xDEADBEEF; cnt[3] becomes 0.
- cnt[7]=2 and writeback of r7 arrives → still stalls that cycle (cnt→1). Issues on the second r7 writeback with bypassed data.
- Issue with rd=4 simultaneous with writeback to r4 → cnt[4] unchanged. rd=0 issue → es_rd_we=0, cnt[0] stays 0.
- Flush while stalled → ds_to_es_valid 0, ds_valid 0 next cycle, no scoreboard change. es_allowin=0 backpressure → ds_allowin=0 and payload held stable.
